temp_bcd_converter: RTL and testbench



---
 rtl/temp_bcd_converter.sv | 98 +++++++++
 tb/tb_temp_bcd_converter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_bcd_converter.sv
// Sequential double-dabble converter: 10-bit temperature to three BCD digits.
// Digits are registered and change only on the cycle that done pulses.
module temp_bcd_converter #(
    parameter int BIN_WIDTH = 10,
    parameter int MAX_VALUE = 999
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIN_WIDTH-1:0] temp_bin,
    input  logic                 temp_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [3:0]           temp_value_100,
    output logic [3:0]           temp_value_10,
    output logic [3:0]           temp_value_1
);

    localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAX_VALUE);
    localparam logic [3:0] LAST_ITER = 4'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [11:0]          bcd;
    logic [BIN_WIDTH-1:0] bin;
    logic [3:0]           cnt;
    logic                 ov_lat;
    logic [11:0]          bcd_adj;
    logic                 accept;

    function automatic logic [3:0] adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign accept  = (state == IDLE) && temp_valid;
    assign bcd_adj = {adj(bcd[11:8]), adj(bcd[7:4]), adj(bcd[3:0])};
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (temp_valid) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_ITER) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Working registers: {bcd, bin} shifts as one 22-bit field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd    <= '0;
            bin    <= '0;
            cnt    <= '0;
            ov_lat <= 1'b0;
        end else if (accept) begin
            bcd    <= '0;
            bin    <= (temp_bin > MAX_BIN) ? MAX_BIN : temp_bin;
            cnt    <= '0;
            ov_lat <= (temp_bin > MAX_BIN);
        end else if (state == SHIFT) begin
            {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
            cnt        <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done           <= 1'b0;
            overflow       <= 1'b0;
            temp_value_100 <= '0;
            temp_value_10  <= '0;
            temp_value_1   <= '0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                overflow       <= ov_lat;
                temp_value_100 <= bcd[11:8];
                temp_value_10  <= bcd[7:4];
                temp_value_1   <= bcd[3:0];
            end
        end
    end

endmodule

// File: tb/tb_temp_bcd_converter.sv
// Directed bench for temp_bcd_converter: timing of busy/done, digit values,
// clamping, ignored requests, back-to-back accepts and mid-conversion reset.
module tb_temp_bcd_converter;

    logic       clk;
    logic       reset;
    logic [9:0] temp_bin;
    logic       temp_valid;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [3:0] temp_value_100;
    logic [3:0] temp_value_10;
    logic [3:0] temp_value_1;

    int n_cmp = 0;
    int n_err = 0;

    temp_bcd_converter dut (
        .clk            (clk),
        .reset          (reset),
        .temp_bin       (temp_bin),
        .temp_valid     (temp_valid),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .temp_value_100 (temp_value_100),
        .temp_value_10  (temp_value_10),
        .temp_value_1   (temp_value_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] digits();
        return {temp_value_100, temp_value_10, temp_value_1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives one accept edge (E0) and leaves temp_valid low afterwards.
    task automatic accept_value(input logic [9:0] v);
        temp_valid = 1'b1;
        temp_bin   = v;
        tick();
        temp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        temp_valid = 1'b0;
        temp_bin = '0;
        ticks(2);
        n_cmp++;
        if ({busy, done, overflow, digits()} !== 15'h0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b ov=%b dig=%h want all 0",
                     busy, done, overflow, digits());
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        accept_value(10'd0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_busy_e0: got %b want 1", busy);
        end
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL zero_busy_e%0d: got busy=%b done=%b want 1/0",
                         e, busy, done);
            end
        end
        tick();
        n_cmp++;
        if ({done, busy, overflow, digits()} !== {3'b100, 12'h000}) begin
            n_err++;
            $display("FAIL zero_e11: got done=%b busy=%b ov=%b dig=%h want 1/0/0 000",
                     done, busy, overflow, digits());
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_e12: got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_987();
        accept_value(10'd987);
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_cmp++;
            if (digits() !== 12'h000 || done !== 1'b0) begin
                n_err++;
                $display("FAIL d987_hold_e%0d: got dig=%h done=%b want 000/0",
                         e, digits(), done);
            end
        end
        tick();
        n_cmp++;
        if (digits() !== 12'h987 || done !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL d987_e11: got dig=%h done=%b ov=%b want 987/1/0",
                     digits(), done, overflow);
        end
        for (int e = 12; e <= 16; e++) begin
            tick();
            n_cmp++;
            if (digits() !== 12'h987 || done !== 1'b0) begin
                n_err++;
                $display("FAIL d987_after_e%0d: got dig=%h done=%b want 987/0",
                         e, digits(), done);
            end
        end
    endtask

    task automatic test_overflow();
        accept_value(10'd1023);
        ticks(11);
        n_cmp++;
        if (digits() !== 12'h999 || overflow !== 1'b1 || done !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_1023: got dig=%h ov=%b done=%b want 999/1/1",
                     digits(), overflow, done);
        end
        tick();
        accept_value(10'd72);
        ticks(10);
        n_cmp++;
        if (overflow !== 1'b1 || digits() !== 12'h999) begin
            n_err++;
            $display("FAIL ovf_hold: got dig=%h ov=%b want 999/1", digits(), overflow);
        end
        tick();
        n_cmp++;
        if (digits() !== 12'h072 || overflow !== 1'b0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_then_72: got dig=%h ov=%b done=%b want 072/0/1",
                     digits(), overflow, done);
        end
        tick();
    endtask

    task automatic test_ignored();
        accept_value(10'd100);
        ticks(4);
        temp_valid = 1'b1;
        temp_bin   = 10'd555;
        tick();
        temp_valid = 1'b0;
        ticks(5);
        temp_valid = 1'b1;
        tick();
        temp_valid = 1'b0;
        n_cmp++;
        if (digits() !== 12'h100 || done !== 1'b1) begin
            n_err++;
            $display("FAIL ign_e11: got dig=%h done=%b want 100/1", digits(), done);
        end
        for (int e = 12; e <= 25; e++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0 || digits() !== 12'h100) begin
                n_err++;
                $display("FAIL ign_hold_e%0d: got busy=%b done=%b dig=%h want 0/0/100",
                         e, busy, done, digits());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  vals [4];
        logic [11:0] exp_d [4];
        int pulses;
        vals  = '{10'd9, 10'd10, 10'd99, 10'd199};
        exp_d = '{12'h009, 12'h010, 12'h099, 12'h199};
        temp_valid = 1'b1;
        temp_bin   = vals[0];
        for (int k = 0; k < 4; k++) begin
            pulses = 0;
            tick();
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_accept_%0d: got busy=%b want 1", k, busy);
            end
            if (k < 3) temp_bin = vals[k+1];
            for (int e = 1; e <= 11; e++) begin
                tick();
                if (done === 1'b1) pulses++;
            end
            n_cmp++;
            if (digits() !== exp_d[k] || done !== 1'b1 || pulses != 1) begin
                n_err++;
                $display("FAIL b2b_result_%0d: got dig=%h done=%b pulses=%0d want %h/1/1",
                         k, digits(), done, pulses, exp_d[k]);
            end
        end
        temp_valid = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        accept_value(10'd456);
        ticks(5);
        @(posedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, overflow, digits()} !== 15'h0) begin
            n_err++;
            $display("FAIL rst_mid: got busy=%b done=%b ov=%b dig=%h want all 0",
                     busy, done, overflow, digits());
        end
        tick();
        reset = 1'b0;
        tick();
        accept_value(10'd456);
        ticks(10);
        n_cmp++;
        if (digits() !== 12'h000 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_after_e10: got dig=%h done=%b want 000/0", digits(), done);
        end
        tick();
        n_cmp++;
        if (digits() !== 12'h456 || done !== 1'b1 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL rst_after_456: got dig=%h done=%b ov=%b want 456/1/0",
                     digits(), done, overflow);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_987();
        test_overflow();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
